multi_op_adder: RTL and testbench
=================================

MULTI_OP_ADDER -- requirements
Module: multi_op_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter MAX_OPS, default 8, maximum operands per packet (>=1); CW = clog2(MAX_OPS+1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operand.
REQ-007 SHALL have port in_data  input  WIDTH  operand.
REQ-008 SHALL have port in_last  input  1  final operand of packet.
REQ-009 SHALL have port cin  input  1  carry-in, sampled on first beat only.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  WIDTH  sum.
REQ-013 SHALL have port out_cout  output  1  unsigned carry-out (true sum >= 2^WIDTH).
REQ-014 SHALL have port out_ovf  output  1  signed overflow (two's-complement sum outside WIDTH range).
REQ-015 SHALL have port out_cnt  output  CW  operands accepted in packet.
REQ-016 SHALL have port out_err  output  1  packet truncated at MAX_OPS.

Function
REQ-017 SHALL implement states IDLE, ACCUM, DONE; in_ready = 1 in IDLE/ACCUM, 0 in DONE.
REQ-018 Beat transfers iff in_valid && in_ready at rising clk.
REQ-019 IDLE beat: unsigned acc = in_data + cin, signed acc = sext(in_data) + cin, cnt = 1; next state ACCUM, or DONE if in_last.
REQ-020 ACCUM beat: unsigned acc += in_data, signed acc += sext(in_data), cnt += 1; DONE if in_last.
REQ-021 Accumulators SHALL be WIDTH+CW bits, never losing carries for up to MAX_OPS operands plus cin.
REQ-022 Beat making cnt == MAX_OPS without in_last SHALL force DONE with out_err = 1; with in_last, out_err = 0.
REQ-023 out_valid SHALL assert the cycle after the terminating beat (latency 1) and hold until out_valid && out_ready.
REQ-024 out_result = acc[WIDTH-1:0] (unless REQ-033); out_cout = OR of unsigned acc bits above WIDTH-1; out_ovf = signed acc outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-025 All out_* SHALL be stable while out_valid && !out_ready.
REQ-026 On output handshake SHALL return to IDLE; next packet accepted no earlier than the following cycle.
REQ-027 in_valid low in ACCUM SHALL hold state and accumulators indefinitely.
REQ-028 Single-beat packet (in_last on first beat) SHALL yield in_data + cin, cnt = 1.

Reset
REQ-029 resetn low SHALL immediately force IDLE, accumulators 0, out_valid 0, out_result 0, out_cout 0, out_ovf 0, out_cnt 0, out_err 0, in_ready 0 while asserted.
REQ-030 Reset mid-packet or during DONE SHALL discard the packet; no partial result emitted.
REQ-031 After resetn deasserts, in_ready SHALL be 1 from the first clk edge.

Configuration
REQ-032 Macro MULTI_OP_ADDER_SAT_EN SHALL select unsigned saturation.
REQ-033 Defined: out_result = {WIDTH{1}} when out_cout = 1, else acc[WIDTH-1:0]; out_cout/out_ovf unchanged.
REQ-034 Undefined: out_result wraps modulo 2^WIDTH; no saturation logic present.

Verification (WIDTH=32, MAX_OPS=8)
REQ-035 cin=1, beats 1,2,3(last) -> out_valid 1 cycle after beat 3, result 0x00000007, cout 0, ovf 0, cnt 3, err 0.
REQ-036 beats 0xFFFFFFFF, 0x00000002(last), cin=0 -> result 0x00000001, cout 1, ovf 0; with SAT_EN result 0xFFFFFFFF.
REQ-037 beats 0x7FFFFFFF, 0x00000001(last) -> result 0x80000000, cout 0, ovf 1.
REQ-038 eight beats of 0x00000001, in_last never set -> result 0x00000008, cnt 8, err 1; in_ready 0 until output handshake.
REQ-039 out_ready low 5 cycles after out_valid -> outputs and out_valid unchanged, in_ready 0; out_ready high -> IDLE next cycle, in_ready 1.
REQ-040 two beats accepted, resetn pulsed low -> out_valid 0 throughout; new packet 0x00000005(last), cin 0 -> result 0x00000005, cnt 1.

Source files
------------

// File: rtl/multi_op_adder.sv
// -----------------------------------------------------------------------------
// multi_op_adder
//
// Adds a packet of WIDTH-bit operands plus a carry-in into one result.
// Operands arrive one per beat on a valid/ready stream. The packet ends on
// in_last, or is cut short once MAX_OPS operands have been taken. One cycle
// after the terminating beat the result is presented on a valid/ready output.
// The result then holds until the consumer takes it.
//
// Parameters
//   WIDTH    operand / result width
//   MAX_OPS  maximum operands per packet (>= 1)
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   in_valid    operand beat valid
//   in_ready    block can accept an operand (IDLE / ACCUM)
//   in_data     operand
//   in_last     final operand of the packet
//   cin         carry-in, used on the first beat only
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_result  sum (wrapped, or saturated when saturation is built in)
//   out_cout    unsigned carry-out: true sum >= 2^WIDTH
//   out_ovf     signed overflow: true signed sum outside WIDTH range
//   out_cnt     operands accepted in the packet
//   out_err     packet was truncated at MAX_OPS operands
//
// Build option
//   MULTI_OP_ADDER_SAT_EN  when defined, out_result saturates to all ones
//                          whenever out_cout is set. When it is undefined,
//                          out_result wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module multi_op_adder #(
  parameter int WIDTH   = 32,
  parameter int MAX_OPS = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_result,
  output logic                         out_cout,
  output logic                         out_ovf,
  output logic [$clog2(MAX_OPS+1)-1:0] out_cnt,
  output logic                         out_err
);

  localparam int CW = $clog2(MAX_OPS + 1);
  // CW extra bits absorb the growth of MAX_OPS operands plus the carry-in,
  // for both the unsigned and the signed view of the running sum.
  localparam int AW = WIDTH + CW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [AW-1:0]     r_acc_u;
  logic [AW-1:0]     r_acc_s;
  logic [CW-1:0]     r_cnt;

  logic              r_in_ready;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_result;
  logic              r_out_cout;
  logic              r_out_ovf;
  logic [CW-1:0]     r_out_cnt;
  logic              r_out_err;

  logic              w_beat;
  logic              w_hs;
  logic              w_first;
  logic [AW-1:0]     w_ext_u;
  logic [AW-1:0]     w_ext_s;
  logic [AW-1:0]     w_cin_ext;
  logic [AW-1:0]     w_base_u;
  logic [AW-1:0]     w_base_s;
  logic [AW-1:0]     w_acc_u_beat;
  logic [AW-1:0]     w_acc_s_beat;
  logic [CW-1:0]     w_cnt_beat;
  logic              w_hit_max;
  logic              w_term;
  logic              w_fin;
  logic [CW:0]       w_sign_bits;
  logic              w_cout_beat;
  logic              w_ovf_beat;
  logic [WIDTH-1:0]  w_res_beat;

  assign w_beat  = in_valid && r_in_ready;
  assign w_hs    = r_out_valid && out_ready;
  assign w_first = (r_state == S_IDLE);

  assign w_ext_u   = {{CW{1'b0}}, in_data};
  assign w_ext_s   = {{CW{in_data[WIDTH-1]}}, in_data};
  assign w_cin_ext = {{(AW-1){1'b0}}, cin};

  // The first beat of a packet starts from the carry-in and not from the
  // previous packet's sum. This folds cin into the same adder.
  assign w_base_u     = w_first ? w_cin_ext : r_acc_u;
  assign w_base_s     = w_first ? w_cin_ext : r_acc_s;
  assign w_acc_u_beat = w_base_u + w_ext_u;
  assign w_acc_s_beat = w_base_s + w_ext_s;
  assign w_cnt_beat   = w_first ? CW'(1) : (r_cnt + CW'(1));

  assign w_hit_max = (w_cnt_beat == CW'(MAX_OPS));
  assign w_term    = in_last || w_hit_max;
  assign w_fin     = w_beat && w_term;

  // The signed sum fits WIDTH bits only when every bit from the WIDTH-1
  // sign position upward is the same.
  assign w_sign_bits = w_acc_s_beat[AW-1:WIDTH-1];
  assign w_cout_beat = |w_acc_u_beat[AW-1:WIDTH];
  assign w_ovf_beat  = !((&w_sign_bits) || !(|w_sign_bits));

`ifdef MULTI_OP_ADDER_SAT_EN
  assign w_res_beat = w_cout_beat ? {WIDTH{1'b1}} : w_acc_u_beat[WIDTH-1:0];
`else
  assign w_res_beat = w_acc_u_beat[WIDTH-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: accept beats in IDLE/ACCUM, wait for handshake in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_beat) begin
          if (w_term) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_DONE: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Running sums and operand count; they hold while no beat transfers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc_u <= {AW{1'b0}};
      r_acc_s <= {AW{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else if (w_beat) begin
      r_acc_u <= w_acc_u_beat;
      r_acc_s <= w_acc_s_beat;
      r_cnt   <= w_cnt_beat;
    end else begin
      r_acc_u <= r_acc_u;
      r_acc_s <= r_acc_s;
      r_cnt   <= r_cnt;
    end
  end

  // Registered handshake flags and result fields. The result is captured
  // from the terminating beat's sum, so it appears one cycle after that beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= {WIDTH{1'b0}};
      r_out_cout   <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_out_cnt    <= {CW{1'b0}};
      r_out_err    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt != S_DONE);
      if (w_fin) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_res_beat;
        r_out_cout   <= w_cout_beat;
        r_out_ovf    <= w_ovf_beat;
        r_out_cnt    <= w_cnt_beat;
        r_out_err    <= !in_last;
      end else if (w_hs) begin
        r_out_valid  <= 1'b0;
      end else begin
        r_out_valid  <= r_out_valid;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_cout   = r_out_cout;
  assign out_ovf    = r_out_ovf;
  assign out_cnt    = r_out_cnt;
  assign out_err    = r_out_err;

endmodule

// File: tb/tb_multi_op_adder.sv
// -----------------------------------------------------------------------------
// tb_multi_op_adder
//
// Self-checking bench for multi_op_adder (WIDTH=32, MAX_OPS=8).
// Expected results come from plain 64-bit arithmetic over the operand list.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_multi_op_adder;

  localparam int WIDTH   = 32;
  localparam int MAX_OPS = 8;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_ovf;
  logic [CW-1:0]    out_cnt;
  logic             out_err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   q_ops[$];
  logic [31:0]   exp_res;
  logic          exp_cout;
  logic          exp_ovf;
  logic [CW-1:0] exp_cnt;
  logic          exp_err;

  multi_op_adder #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .cin        (cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .out_cnt    (out_cnt),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_op();
    case ($urandom_range(5, 0))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(15, 0));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference: true unsigned and signed sums in 64-bit arithmetic.
  task automatic model(input logic c, input bit use_last);
    longint unsigned su;
    longint          ss;
    su = {63'd0, c};
    ss = longint'({63'd0, c});
    foreach (q_ops[i]) begin
      su += {32'd0, q_ops[i]};
      ss += longint'($signed(q_ops[i]));
    end
    exp_res  = su[31:0];
    exp_cout = (su[63:32] != 32'd0);
    exp_ovf  = (ss > longint'(32'sh7FFF_FFFF)) || (ss < longint'(32'sh8000_0000));
`ifdef MULTI_OP_ADDER_SAT_EN
    if (exp_cout) exp_res = 32'hFFFF_FFFF;
`endif
    exp_cnt  = CW'(q_ops.size());
    exp_err  = !use_last;
  endtask

  // Sends q_ops as beats; optional idle gaps exercise the hold behaviour.
  // Returns at the falling edge after the last beat's rising edge.
  task automatic drive_packet(input logic c, input bit use_last, input int gap_max,
                              output bit tmo);
    tmo = 1'b0;
    for (int i = 0; i < q_ops.size(); i++) begin
      int g;
      int t;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom_range(1, 0));
        cin      = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = q_ops[i];
      in_last  = use_last && (i == q_ops.size() - 1);
      cin      = (i == 0) ? c : 1'($urandom_range(1, 0));
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) tmo = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_last   = 1'b1;
    cin       = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b r=%h c=%b o=%b n=%0d e=%b rdy=%b want all 0",
               out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready);
    end
    in_valid = 1'b0;
    resetn   = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    bit                   tmo;
    logic                 c;
    logic [31:0]          e_res;
    logic                 e_cout;
    logic                 e_ovf;
    logic [CW-1:0]        e_cnt;
    for (int t = 0; t < 3; t++) begin
      q_ops.delete();
      case (t)
        0: begin
          q_ops.push_back(32'd1); q_ops.push_back(32'd2); q_ops.push_back(32'd3);
          c = 1'b1; e_res = 32'h0000_0007; e_cout = 1'b0; e_ovf = 1'b0; e_cnt = CW'(3);
        end
        1: begin
          q_ops.push_back(32'hFFFF_FFFF); q_ops.push_back(32'h0000_0002);
          c = 1'b0; e_cout = 1'b1; e_ovf = 1'b0; e_cnt = CW'(2);
`ifdef MULTI_OP_ADDER_SAT_EN
          e_res = 32'hFFFF_FFFF;
`else
          e_res = 32'h0000_0001;
`endif
        end
        default: begin
          q_ops.push_back(32'h7FFF_FFFF); q_ops.push_back(32'h0000_0001);
          c = 1'b0; e_res = 32'h8000_0000; e_cout = 1'b0; e_ovf = 1'b1; e_cnt = CW'(2);
        end
      endcase
      drive_packet(c, 1'b1, 0, tmo);
      n_vec++;
      if (tmo || {out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready}
                 !== {1'b1, e_res, e_cout, e_ovf, e_cnt, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL directed_%0d: got v=%b r=%h c=%b o=%b n=%0d e=%b rdy=%b tmo=%b want v=1 r=%h c=%b o=%b n=%0d e=0 rdy=0",
                 t, out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready, tmo,
                 e_res, e_cout, e_ovf, e_cnt);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed_%0d_release: got v=%b rdy=%b want v=0 rdy=1", t, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_truncation();
    bit tmo;
    q_ops.delete();
    repeat (MAX_OPS) q_ops.push_back(32'd1);
    drive_packet(1'b0, 1'b0, 0, tmo);
    n_vec++;
    if (tmo || {out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready}
               !== {1'b1, 32'h0000_0008, 1'b0, 1'b0, CW'(8), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL truncation: got v=%b r=%h c=%b o=%b n=%0d e=%b rdy=%b tmo=%b want v=1 r=00000008 c=0 o=0 n=8 e=1 rdy=0",
               out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready, tmo);
    end
    // A ninth beat offered while the result waits must not be taken.
    in_valid = 1'b1;
    in_data  = 32'd100;
    in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h0000_0008 || out_cnt !== CW'(8)) begin
        n_err++;
        $display("FAIL truncation_hold_%0d: got rdy=%b v=%b r=%h n=%0d want rdy=0 v=1 r=00000008 n=8",
                 k, in_ready, out_valid, out_result, out_cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    q_ops.delete();
    q_ops.push_back(32'd9);
    drive_packet(1'b0, 1'b1, 0, tmo);
    n_vec++;
    if (tmo || out_result !== 32'd9 || out_cnt !== CW'(1) || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL truncation_next: got r=%h n=%0d e=%b tmo=%b want r=00000009 n=1 e=0",
               out_result, out_cnt, out_err, tmo);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit   tmo;
    logic c;
    q_ops.delete();
    repeat (3) q_ops.push_back(rand_op());
    c = 1'($urandom_range(1, 0));
    model(c, 1'b1);
    drive_packet(c, 1'b1, 0, tmo);
    in_valid = 1'b1;
    in_data  = $urandom;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (tmo || {out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready}
                 !== {1'b1, exp_res, exp_cout, exp_ovf, exp_cnt, exp_err, 1'b0}) begin
        n_err++;
        $display("FAIL backpressure_%0d: got v=%b r=%h c=%b o=%b n=%0d e=%b rdy=%b want v=1 r=%h c=%b o=%b n=%0d e=%b rdy=0",
                 k, out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready,
                 exp_res, exp_cout, exp_ovf, exp_cnt, exp_err);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit tmo;
    q_ops.delete();
    q_ops.push_back(rand_op());
    q_ops.push_back(rand_op());
    drive_packet(1'b1, 1'b0, 0, tmo);
    resetn = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_assert: got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    q_ops.delete();
    q_ops.push_back(32'd5);
    drive_packet(1'b0, 1'b1, 0, tmo);
    n_vec++;
    if (tmo || {out_valid, out_result, out_cout, out_ovf, out_cnt, out_err}
               !== {1'b1, 32'h0000_0005, 1'b0, 1'b0, CW'(1), 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_next: got v=%b r=%h c=%b o=%b n=%0d e=%b want v=1 r=00000005 c=0 o=0 n=1 e=0",
               out_valid, out_result, out_cout, out_ovf, out_cnt, out_err);
    end
    // Reset while the result is waiting discards it.
    resetn = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_result !== 32'd0 || out_cnt !== CW'(0)) begin
      n_err++;
      $display("FAIL reset_done: got v=%b r=%h n=%0d want v=0 r=00000000 n=0", out_valid, out_result, out_cnt);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_done_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    bit   tmo;
    bit   use_last;
    logic c;
    int   len;
    int   w;
    for (int p = 0; p < 60; p++) begin
      q_ops.delete();
      len = $urandom_range(MAX_OPS, 1);
      for (int i = 0; i < len; i++) q_ops.push_back(rand_op());
      use_last = (len < MAX_OPS) ? 1'b1 : 1'($urandom_range(1, 0));
      c = 1'($urandom_range(1, 0));
      model(c, use_last);
      drive_packet(c, use_last, 2, tmo);
      n_vec++;
      if (tmo || {out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready}
                 !== {1'b1, exp_res, exp_cout, exp_ovf, exp_cnt, exp_err, 1'b0}) begin
        n_err++;
        $display("FAIL random_%0d: got v=%b r=%h c=%b o=%b n=%0d e=%b rdy=%b tmo=%b want v=1 r=%h c=%b o=%b n=%0d e=%b rdy=0",
                 p, out_valid, out_result, out_cout, out_ovf, out_cnt, out_err, in_ready, tmo,
                 exp_res, exp_cout, exp_ovf, exp_cnt, exp_err);
      end
      w = $urandom_range(2, 0);
      repeat (w) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL random_%0d_release: got v=%b rdy=%b want v=0 rdy=1", p, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_truncation();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
